// File: rtl/memory_io_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC-3 memory / memory-mapped I/O controller:
// access FSM state encoding, device register addresses and the default
// number of RAM wait states. No ports (package).
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

    localparam int unsigned WAIT_STATES_DEFAULT = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] ADDR_IO_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_KBSR    = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR    = 16'hFE02;
    localparam logic [15:0] ADDR_DSR     = 16'hFE04;
    localparam logic [15:0] ADDR_DDR     = 16'hFE06;
    localparam logic [15:0] ADDR_MCR     = 16'hFFFE;

    // Everything from xFE00 upward is device space (mapped or not).
    function automatic logic is_io_addr(input logic [15:0] addr);
        return (addr >= ADDR_IO_BASE);
    endfunction

endpackage

// File: rtl/memory_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// memory_io_ctrl_if
// Bundles the processor-side access handshake, the RAM data path and the
// keyboard/display device signals of memory_io_ctrl.
//   master : processor / memory / devices side (drives requests and inputs)
//   slave  : the controller (drives Memory_WE, Mem_Ready, Read_Data, display,
//            Kbd_Int and Run)
// ---------------------------------------------------------------------------
interface memory_io_ctrl_if;
    logic        Mem_Req;
    logic        Mem_RW;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Memory_Out;
    logic [7:0]  Kbd_Data;
    logic        Kbd_Valid;
    logic        Disp_Ack;
    logic        Memory_WE;
    logic        Mem_Ready;
    logic [15:0] Read_Data;
    logic [7:0]  Disp_Data;
    logic        Disp_Valid;
    logic        Kbd_Int;
    logic        Run;

    modport master (
        output Mem_Req, Mem_RW, MAR, MDR, Memory_Out, Kbd_Data, Kbd_Valid, Disp_Ack,
        input  Memory_WE, Mem_Ready, Read_Data, Disp_Data, Disp_Valid, Kbd_Int, Run
    );

    modport slave (
        input  Mem_Req, Mem_RW, MAR, MDR, Memory_Out, Kbd_Data, Kbd_Valid, Disp_Ack,
        output Memory_WE, Mem_Ready, Read_Data, Disp_Data, Disp_Valid, Kbd_Int, Run
    );
endinterface

// File: rtl/memory_io_ctrl_mmio_regs.sv
// ---------------------------------------------------------------------------
// mmio_regs
// Device registers KBSR/KBDR/DSR/DDR/MCR with the keyboard and display
// handshakes.
//   clk, rst      : clock, asynchronous active-high reset
//   io_done       : DONE cycle of an I/O access (side effects happen here)
//   io_we         : that access is a write
//   io_addr       : address of that access
//   io_wdata      : {MDR[15], MDR[14], MDR[7:0]} of that access
//   rd_addr       : address for the combinational read mux
//   rd_data       : register value at rd_addr (x0000 when unmapped)
//   kbd_data/kbd_valid : keyboard character strobe
//   disp_ack      : display consumed disp_data
//   disp_data/disp_valid, kbd_int, run : registered device outputs
// ---------------------------------------------------------------------------
module mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        io_done,
    input  logic        io_we,
    input  logic [15:0] io_addr,
    input  logic [9:0]  io_wdata,
    input  logic [15:0] rd_addr,
    output logic [15:0] rd_data,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    input  logic        disp_ack,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    output logic        kbd_int,
    output logic        run
);

    logic       kb_rdy_q, kb_rdy_d;
    logic       kb_ie_q, kb_ie_d;
    logic [7:0] kb_char_q, kb_char_d;
    logic       ds_rdy_q, ds_rdy_d;
    logic       ds_ie_q, ds_ie_d;
    logic [7:0] disp_data_q, disp_data_d;
    logic       disp_valid_q, disp_valid_d;
    logic       run_q, run_d;
    logic       kbd_int_q, kbd_int_d;
    logic       kbdr_read_s;
    logic       io_wr_s;

    assign kbdr_read_s = io_done && !io_we && (io_addr == ADDR_KBDR);
    assign io_wr_s     = io_done && io_we;

    // Next-state for all device registers and handshakes.
    always_comb begin
        kb_ie_d      = kb_ie_q;
        ds_rdy_d     = ds_rdy_q;
        ds_ie_d      = ds_ie_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        run_d        = run_q;

        if (kbdr_read_s) begin
            kb_rdy_d = 1'b0;
        end else begin
            kb_rdy_d = kb_rdy_q;
        end

        // A completing KBDR read frees the buffer in the same cycle, so a
        // simultaneous character is taken rather than dropped.
        if (kbd_valid && (!kb_rdy_q || kbdr_read_s)) begin
            kb_char_d = kbd_data;
            kb_rdy_d  = 1'b1;
        end else begin
            kb_char_d = kb_char_q;
        end

        if (disp_ack) begin
            disp_valid_d = 1'b0;
            ds_rdy_d     = 1'b1;
        end else begin
            disp_valid_d = disp_valid_q;
        end

        // Applied after the ack so a same-cycle DDR write wins.
        if (io_wr_s) begin
            case (io_addr)
                ADDR_KBSR: kb_ie_d = io_wdata[8];
                ADDR_DSR:  ds_ie_d = io_wdata[8];
                ADDR_DDR: begin
                    disp_data_d  = io_wdata[7:0];
                    disp_valid_d = 1'b1;
                    ds_rdy_d     = 1'b0;
                end
                ADDR_MCR:  run_d = io_wdata[9];
                default:   run_d = run_q;
            endcase
        end else begin
            run_d = run_q;
        end

        kbd_int_d = kb_rdy_d & kb_ie_d;
    end

    // Read mux for the register addressed by the pending request.
    always_comb begin
        rd_data = 16'h0000;
        case (rd_addr)
            ADDR_KBSR: rd_data = {kb_rdy_q, kb_ie_q, 14'd0};
            ADDR_KBDR: rd_data = {8'h00, kb_char_q};
            ADDR_DSR:  rd_data = {ds_rdy_q, ds_ie_q, 14'd0};
            ADDR_DDR:  rd_data = {8'h00, disp_data_q};
            ADDR_MCR:  rd_data = {run_q, 15'd0};
            default:   rd_data = 16'h0000;
        endcase
    end

    // Device register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_rdy_q     <= 1'b0;
            kb_ie_q      <= 1'b0;
            kb_char_q    <= 8'h00;
            ds_rdy_q     <= 1'b1;
            ds_ie_q      <= 1'b0;
            disp_data_q  <= 8'h00;
            disp_valid_q <= 1'b0;
            run_q        <= 1'b1;
            kbd_int_q    <= 1'b0;
        end else begin
            kb_rdy_q     <= kb_rdy_d;
            kb_ie_q      <= kb_ie_d;
            kb_char_q    <= kb_char_d;
            ds_rdy_q     <= ds_rdy_d;
            ds_ie_q      <= ds_ie_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            run_q        <= run_d;
            kbd_int_q    <= kbd_int_d;
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign kbd_int    = kbd_int_q;
    assign run        = run_q;

endmodule

// File: rtl/memory_io_ctrl.sv
// ---------------------------------------------------------------------------
// memory_io_ctrl
// LC-3 memory controller: sequences RAM accesses through WAIT_STATES wait
// cycles, produces the one-cycle write enable and ready pulses, and routes
// xFE00-xFFFF to the device registers in mmio_regs.
//   Clk   : clock
//   Reset : asynchronous active-high reset
//   bus   : memory_io_ctrl_if.slave (request, RAM data path, devices)
// ---------------------------------------------------------------------------
module memory_io_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset,
    memory_io_ctrl_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 32'd1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [9:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [15:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        rdy_q, rdy_d;
    logic        io_done_s;
    logic [15:0] io_rdata_s;

    assign io_done_s = (state_q == ST_DONE) && is_io_addr(addr_q);

    mmio_regs u_mmio_regs (
        .clk        (Clk),
        .rst        (Reset),
        .io_done    (io_done_s),
        .io_we      (rw_q),
        .io_addr    (addr_q),
        .io_wdata   (wdata_q),
        .rd_addr    (bus.MAR),
        .rd_data    (io_rdata_s),
        .kbd_data   (bus.Kbd_Data),
        .kbd_valid  (bus.Kbd_Valid),
        .disp_ack   (bus.Disp_Ack),
        .disp_data  (bus.Disp_Data),
        .disp_valid (bus.Disp_Valid),
        .kbd_int    (bus.Kbd_Int),
        .run        (bus.Run)
    );

    // Access FSM next state, wait counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Mem_Req) begin
                    // Request is latched so a dropped Mem_Req cannot abort it.
                    addr_d  = bus.MAR;
                    rw_d    = bus.Mem_RW;
                    wdata_d = {bus.MDR[15:14], bus.MDR[7:0]};
                    if (is_io_addr(bus.MAR)) begin
                        state_d = ST_DONE;
                        rdata_d = io_rdata_s;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (rw_q) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_DONE;
                        rdata_d = bus.Memory_Out;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                rdata_d = bus.Memory_Out;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Strobes are registered from the state being entered.
        we_d  = (state_d == ST_WRITE);
        rdy_d = (state_d == ST_DONE);
    end

    // Access FSM state, counter and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 10'd0;
            rw_q    <= 1'b0;
            rdata_q <= 16'h0000;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.Memory_WE = we_q;
    assign bus.Mem_Ready = rdy_q;
    assign bus.Read_Data = rdata_q;

endmodule

// File: tb/tb_memory_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_memory_io_ctrl
// Directed bench for memory_io_ctrl (WAIT_STATES=2). A register-level model
// of the device map and the access latencies predicts every cycle's
// strobes and device outputs; literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_memory_io_ctrl;

    localparam int WS = 2;

    logic clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_we = -1;
    int   exp_rdy = -1;

    // model of the device registers
    logic       m_kb_rdy, m_kb_ie, m_ds_rdy, m_ds_ie, m_dvalid, m_run;
    logic [7:0] m_kb_char, m_disp;

    logic [15:0] rd;
    int          lat, we_rel;

    memory_io_ctrl_if bus();

    memory_io_ctrl #(.WAIT_STATES(WS)) dut (
        .Clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_kb_rdy = 1'b0; m_kb_ie = 1'b0; m_kb_char = 8'h00;
        m_ds_rdy = 1'b1; m_ds_ie = 1'b0; m_disp = 8'h00;
        m_dvalid = 1'b0; m_run = 1'b1;
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        case (a)
            16'hFE00: return {m_kb_rdy, m_kb_ie, 14'd0};
            16'hFE02: return {8'h00, m_kb_char};
            16'hFE04: return {m_ds_rdy, m_ds_ie, 14'd0};
            16'hFE06: return {8'h00, m_disp};
            16'hFFFE: return {m_run, 15'd0};
            default:  return 16'h0000;
        endcase
    endfunction

    // Effects of a completed access plus a strobe (1=kbd, 2=disp ack) in its DONE cycle.
    task automatic m_apply(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                           input int side, input logic [7:0] sd);
        logic was_rdy, kbdr_rd, ddr_wr;
        was_rdy = m_kb_rdy;
        kbdr_rd = !rw && (a == 16'hFE02);
        ddr_wr  = rw && (a == 16'hFE06);
        if (rw) begin
            case (a)
                16'hFE00: m_kb_ie = wd[14];
                16'hFE04: m_ds_ie = wd[14];
                16'hFE06: begin m_disp = wd[7:0]; m_dvalid = 1'b1; m_ds_rdy = 1'b0; end
                16'hFFFE: m_run = wd[15];
                default: ;
            endcase
        end
        if (kbdr_rd) m_kb_rdy = 1'b0;
        if (side == 1 && (!was_rdy || kbdr_rd)) begin m_kb_char = sd; m_kb_rdy = 1'b1; end
        if (side == 2 && !ddr_wr) begin m_dvalid = 1'b0; m_ds_rdy = 1'b1; end
    endtask

    // Per-cycle comparison of strobes and device outputs against the model.
    always @(negedge clk) begin
        if (Reset === 1'b0) begin
            chk("mem_we",     bus.Memory_WE,  cyc == exp_we);
            chk("mem_ready",  bus.Mem_Ready,  cyc == exp_rdy);
            chk("disp_valid", bus.Disp_Valid, m_dvalid);
            chk("disp_data",  bus.Disp_Data,  m_disp);
            chk("kbd_int",    bus.Kbd_Int,    m_kb_rdy & m_kb_ie);
            chk("run",        bus.Run,        m_run);
        end
    end

    task automatic access(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] mo, input int side, input logic [7:0] sd,
                          input logic drop, output logic [15:0] rdo, output int lato,
                          output int we_o);
        int start, n;
        logic io;
        logic [15:0] exp_rd;
        @(negedge clk);
        bus.Mem_Req = 1'b1; bus.Mem_RW = rw; bus.MAR = a; bus.MDR = wd; bus.Memory_Out = mo;
        start = cyc;
        io = (a >= 16'hFE00);
        if (io) begin
            exp_rdy = start + 1; exp_we = -1;
        end else begin
            exp_rdy = start + WS + 1 + (rw ? 1 : 0);
            exp_we  = rw ? start + WS + 1 : -1;
        end
        exp_rd = io ? m_read(a) : mo;
        if (drop) begin @(posedge clk); #1 bus.Mem_Req = 1'b0; end
        lato = -1; we_o = -1; n = 0;
        while (lato < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.Memory_WE === 1'b1) we_o = cyc - start;
            if (bus.Mem_Ready === 1'b1) lato = cyc - start;
        end
        if (lato < 0) chk("ready_timeout", 32'd0, 32'd1);
        rdo = bus.Read_Data;
        chk("read_data_model", bus.Read_Data, exp_rd);
        if (side == 1) begin bus.Kbd_Valid = 1'b1; bus.Kbd_Data = sd; end
        if (side == 2) bus.Disp_Ack = 1'b1;
        @(posedge clk); #1;
        bus.Mem_Req = 1'b0; bus.Kbd_Valid = 1'b0; bus.Disp_Ack = 1'b0;
        m_apply(rw, a, wd, side, sd);
    endtask

    task automatic kbd_strobe(input logic [7:0] d);
        @(negedge clk);
        bus.Kbd_Valid = 1'b1; bus.Kbd_Data = d;
        @(posedge clk); #1 bus.Kbd_Valid = 1'b0;
        if (!m_kb_rdy) begin m_kb_char = d; m_kb_rdy = 1'b1; end
    endtask

    task automatic disp_ack_pulse();
        @(negedge clk);
        bus.Disp_Ack = 1'b1;
        @(posedge clk); #1 bus.Disp_Ack = 1'b0;
        m_dvalid = 1'b0; m_ds_rdy = 1'b1;
    endtask

    task automatic rd_io(input logic [15:0] a, input logic [15:0] lit, input string nm);
        access(1'b0, a, 16'h0000, 16'h0000, 0, 8'h00, 1'b0, rd, lat, we_rel);
        chk(nm, rd, lit);
        chk({nm, "_lat"}, lat, 32'd1);
    endtask

    task automatic wr_io(input logic [15:0] a, input logic [15:0] wd, input int side);
        access(1'b1, a, wd, 16'h0000, side, 8'h00, 1'b0, rd, lat, we_rel);
        chk("io_write_no_we", we_rel, 32'hFFFF_FFFF);
    endtask

    initial begin
        int start, n;
        Reset = 1'b1;
        bus.Mem_Req = 1'b0; bus.Mem_RW = 1'b0; bus.MAR = 16'h0000; bus.MDR = 16'h0000;
        bus.Memory_Out = 16'h0000; bus.Kbd_Data = 8'h00; bus.Kbd_Valid = 1'b0; bus.Disp_Ack = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_we",    bus.Memory_WE,  32'd0);
        chk("rst_ready", bus.Mem_Ready,  32'd0);
        chk("rst_rdata", bus.Read_Data,  32'h0000);
        chk("rst_dval",  bus.Disp_Valid, 32'd0);
        chk("rst_ddata", bus.Disp_Data,  32'h00);
        chk("rst_kint",  bus.Kbd_Int,    32'd0);
        chk("rst_run",   bus.Run,        32'd1);
        @(posedge clk); #1 Reset = 1'b0;

        // RAM read / write latency and data
        access(1'b0, 16'h3000, 16'h0000, 16'h1234, 0, 8'h00, 1'b0, rd, lat, we_rel);
        chk("ram_rd_data", rd, 32'h1234);
        chk("ram_rd_lat", lat, 32'd3);
        chk("ram_rd_no_we", we_rel, 32'hFFFF_FFFF);
        access(1'b1, 16'h3001, 16'hBEEF, 16'h0000, 0, 8'h00, 1'b0, rd, lat, we_rel);
        chk("ram_wr_lat", lat, 32'd4);
        chk("ram_wr_we_cycle", we_rel, 32'd3);
        access(1'b0, 16'h2000, 16'h0000, 16'h5A5A, 0, 8'h00, 1'b1, rd, lat, we_rel);
        chk("ram_rd_drop_data", rd, 32'h5A5A);
        chk("ram_rd_drop_lat", lat, 32'd3);
        access(1'b1, 16'hFDFF, 16'h0001, 16'h0000, 0, 8'h00, 1'b0, rd, lat, we_rel);
        chk("ram_top_wr_lat", lat, 32'd4);

        // keyboard
        kbd_strobe(8'h41);
        rd_io(16'hFE00, 16'h8000, "kbsr_ready");
        rd_io(16'hFE02, 16'h0041, "kbdr_41");
        rd_io(16'hFE00, 16'h0000, "kbsr_cleared");
        wr_io(16'hFE00, 16'h4000, 0);
        kbd_strobe(8'h55);
        kbd_strobe(8'h66);
        rd_io(16'hFE00, 16'hC000, "kbsr_ie_ready");
        rd_io(16'hFE02, 16'h0055, "kbdr_drop");
        kbd_strobe(8'h41);
        access(1'b0, 16'hFE02, 16'h0000, 16'h0000, 1, 8'h42, 1'b0, rd, lat, we_rel);
        chk("kbdr_same_cycle", rd, 32'h0041);
        rd_io(16'hFE00, 16'hC000, "kbsr_still_ready");
        rd_io(16'hFE02, 16'h0042, "kbdr_42");
        wr_io(16'hFE00, 16'h0000, 0);

        // display
        wr_io(16'hFE06, 16'h0058, 0);
        chk("disp_data_58", bus.Disp_Data, 32'h58);
        chk("disp_valid_set", bus.Disp_Valid, 32'd1);
        rd_io(16'hFE04, 16'h0000, "dsr_busy");
        disp_ack_pulse();
        rd_io(16'hFE04, 16'h8000, "dsr_ready");
        wr_io(16'hFE06, 16'h0059, 2);
        chk("ddr_wins_valid", bus.Disp_Valid, 32'd1);
        rd_io(16'hFE04, 16'h0000, "ddr_wins_dsr");

        // MCR, unmapped, read-only
        rd_io(16'hFFFE, 16'h8000, "mcr_rst");
        wr_io(16'hFFFE, 16'h0000, 0);
        chk("run_cleared", bus.Run, 32'd0);
        rd_io(16'hFFFE, 16'h0000, "mcr_zero");
        rd_io(16'hFE10, 16'h0000, "unmapped_rd");
        wr_io(16'hFE10, 16'hFFFF, 0);
        wr_io(16'hFE02, 16'h00AA, 0);
        rd_io(16'hFE02, 16'h0042, "kbdr_ro");

        // reset in the WRITE cycle
        @(negedge clk);
        bus.Mem_Req = 1'b1; bus.Mem_RW = 1'b1; bus.MAR = 16'h3002; bus.MDR = 16'h1111;
        start = cyc; exp_we = start + WS + 1; exp_rdy = start + WS + 2;
        n = 0;
        while (bus.Memory_WE !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("rst_test_we_cycle", cyc - start, 32'd3);
        #1 Reset = 1'b1;
        exp_we = -1; exp_rdy = -1;
        #1;
        chk("async_we_drop",   bus.Memory_WE,  32'd0);
        chk("async_rdy_drop",  bus.Mem_Ready,  32'd0);
        chk("async_run",       bus.Run,        32'd1);
        chk("async_dval",      bus.Disp_Valid, 32'd0);
        bus.Mem_Req = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        @(posedge clk); #1 Reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_rdata", bus.Read_Data, 32'h0000);
        rd_io(16'hFFFE, 16'h8000, "mcr_after_rst");
        rd_io(16'hFE04, 16'h8000, "dsr_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
